// File: rtl/uc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uc_pkg
// Description : Shared definitions for the multi-cycle control unit: opcode
//               encodings, FSM state type and the illegal-opcode predicate.
// Revision    : 1.0 - initial release
// ============================================================================
package uc_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_OUT  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_REP  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    // 011 and 110 are the two unassigned encodings.
    function automatic logic is_illegal(input logic [2:0] op);
        return (op == 3'b011) || (op == 3'b110);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec_onehot.sv
`default_nettype none
// ============================================================================
// Module      : dec_onehot
// Description : Index to one-hot decoder with enable; output is all-zero
//               when the enable is low.
// Ports       : i_idx    - bit index to set
//               i_en     - decode enable
//               o_onehot - N-bit one-hot (or zero) vector
// Revision    : 1.0 - initial release
// ============================================================================
module dec_onehot #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic             i_en,
    output logic [N-1:0]     o_onehot
);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            assign o_onehot[i] = i_en && (i_idx == IDX_W'(i));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uc_multiciclo_param.sv
`default_nettype none
// ============================================================================
// Module      : uc_multiciclo_param
// Description : Parametrised multi-cycle control unit for the accumulator
//               datapath. A Run request in IDLE latches the instruction into
//               IR; the FSM then walks T1..T3 as the opcode needs and pulses
//               Done in the final step. All control outputs are Moore-decoded
//               from the registered state and IR.
// Ports       : Clock, Reset (sync, active-high), Run, Iin  - inputs
//               Done, Busy, OpSelect, RegNumSelect, Imediato,
//               Aenable, Renable, Rselect, Iselect, OutEnable,
//               Illegal, RegEnable (one-hot)                - outputs
// Revision    : 1.0 - initial release
// ============================================================================
module uc_multiciclo_param
    import uc_pkg::*;
#(
    parameter int INSTR_W  = 16,
    parameter int NREG     = 8,
    parameter int REG_BITS = $clog2(NREG),
    parameter int IMM_W    = INSTR_W - 3 - REG_BITS
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Run,
    input  logic [INSTR_W-1:0]  Iin,
    output logic                Done,
    output logic                Busy,
    output logic [2:0]          OpSelect,
    output logic [REG_BITS-1:0] RegNumSelect,
    output logic [IMM_W-1:0]    Imediato,
    output logic                Aenable,
    output logic                Renable,
    output logic                Rselect,
    output logic                Iselect,
    output logic                OutEnable,
    output logic                Illegal,
    output logic [NREG-1:0]     RegEnable
);

    state_t               r_state;
    logic [INSTR_W-1:0]   r_ir;

    logic [2:0]           w_op;
    logic [REG_BITS-1:0]  w_rx;
    logic [REG_BITS-1:0]  w_ry;
    logic [IMM_W-1:0]     w_imm;
    logic                 w_illegal;
    logic                 w_wr_en;

    assign w_op      = r_ir[INSTR_W-1 -: 3];
    assign w_rx      = r_ir[INSTR_W-4 -: REG_BITS];
    assign w_ry      = r_ir[INSTR_W-4-REG_BITS -: REG_BITS];
    assign w_imm     = r_ir[IMM_W-1:0];
    assign w_illegal = is_illegal(w_op);

    // State and instruction register. Iin is only looked at in IDLE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_ir    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Run) begin
                        r_ir    <= Iin;
                        r_state <= T1;
                    end
                end
                T1: begin
                    if (w_illegal || (w_op == OP_LDI))
                        r_state <= IDLE;
                    else
                        r_state <= T2;
                end
                T2: begin
                    if (w_op == OP_OUT)
                        r_state <= IDLE;
                    else
                        r_state <= T3;
                end
                T3:      r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Moore output decode: everything defaults to 0 and is raised only in the
    // state/opcode combinations that need it.
    always_comb begin
        Done         = 1'b0;
        Busy         = (r_state != IDLE);
        OpSelect     = (r_state != IDLE) ? w_op : 3'b000;
        RegNumSelect = '0;
        Imediato     = '0;
        Aenable      = 1'b0;
        Renable      = 1'b0;
        Rselect      = 1'b0;
        Iselect      = 1'b0;
        OutEnable    = 1'b0;
        Illegal      = 1'b0;
        w_wr_en      = 1'b0;

        case (r_state)
            IDLE: ;
            T1: begin
                if (w_illegal) begin
                    Illegal = 1'b1;
                    Done    = 1'b1;
                end else if (w_op == OP_LDI) begin
                    Iselect  = 1'b1;
                    Imediato = w_imm;
                    w_wr_en  = 1'b1;
                    Done     = 1'b1;
                end else if (w_op == OP_REP) begin
                    // rep copies rY into rX, so A is loaded from rY.
                    Aenable      = 1'b1;
                    RegNumSelect = w_ry;
                end else begin
                    Aenable      = 1'b1;
                    RegNumSelect = w_rx;
                end
            end
            T2: begin
                if (w_op == OP_OUT) begin
                    OutEnable = 1'b1;
                    Done      = 1'b1;
                end else begin
                    // rep relies on the ALU passing A through for op 111,
                    // so no second operand is selected.
                    Renable = 1'b1;
                    if (w_op != OP_REP)
                        RegNumSelect = w_ry;
                end
            end
            T3: begin
                Rselect = 1'b1;
                w_wr_en = 1'b1;
                Done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Destination is always rX; the enable gates the whole vector to zero.
    dec_onehot #(
        .N     (NREG),
        .IDX_W (REG_BITS)
    ) u_dec_onehot (
        .i_idx    (w_rx),
        .i_en     (w_wr_en),
        .o_onehot (RegEnable)
    );

endmodule
`default_nettype wire

// File: tb/tb_uc_multiciclo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uc_multiciclo_param
// Description : Self-checking bench for uc_multiciclo_param (NREG=8,
//               INSTR_W=16). Each instruction is expanded by a reference
//               model into its expected per-cycle output list, which is then
//               compared against the DUT cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uc_multiciclo_param;

    localparam int INSTR_W  = 16;
    localparam int NREG     = 8;
    localparam int REG_BITS = 3;
    localparam int IMM_W    = INSTR_W - 3 - REG_BITS;

    typedef struct packed {
        logic                done;
        logic                busy;
        logic [2:0]          opsel;
        logic [REG_BITS-1:0] regnum;
        logic [IMM_W-1:0]    imm;
        logic                aen;
        logic                ren;
        logic                rsel;
        logic                isel;
        logic                outen;
        logic                ill;
        logic [NREG-1:0]     regen;
    } outs_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                run;
    logic [INSTR_W-1:0]  iin;

    logic                done, busy, aen, ren, rsel, isel, outen, ill;
    logic [2:0]          opsel;
    logic [REG_BITS-1:0] regnum;
    logic [IMM_W-1:0]    imm;
    logic [NREG-1:0]     regen;

    outs_t obs;
    assign obs = '{done: done, busy: busy, opsel: opsel, regnum: regnum,
                   imm: imm, aen: aen, ren: ren, rsel: rsel, isel: isel,
                   outen: outen, ill: ill, regen: regen};

    int    n_cmp = 0;
    int    n_err = 0;
    outs_t exp_q[$];

    always #5 clk = ~clk;

    uc_multiciclo_param #(
        .INSTR_W (INSTR_W),
        .NREG    (NREG)
    ) dut (
        .Clock        (clk),
        .Reset        (rst),
        .Run          (run),
        .Iin          (iin),
        .Done         (done),
        .Busy         (busy),
        .OpSelect     (opsel),
        .RegNumSelect (regnum),
        .Imediato     (imm),
        .Aenable      (aen),
        .Renable      (ren),
        .Rselect      (rsel),
        .Iselect      (isel),
        .OutEnable    (outen),
        .Illegal      (ill),
        .RegEnable    (regen)
    );

    task automatic chk(input string tag, input outs_t e);
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Reference model: the list of output vectors, one per cycle from T1 to
    // the Done cycle, that the instruction must produce.
    function automatic void build(input logic [INSTR_W-1:0] ins);
        logic [2:0]          op;
        logic [REG_BITS-1:0] rx, ry;
        outs_t               b, c;
        op = ins[15:13];
        rx = ins[12:10];
        ry = ins[9:7];
        exp_q.delete();
        b = '0;
        b.busy  = 1'b1;
        b.opsel = op;
        if (op == 3'b011 || op == 3'b110) begin
            c = b; c.ill = 1'b1; c.done = 1'b1; exp_q.push_back(c);
        end else if (op == 3'b101) begin
            c = b; c.isel = 1'b1; c.imm = ins[9:0];
            c.regen = NREG'(1) << rx; c.done = 1'b1; exp_q.push_back(c);
        end else if (op == 3'b100) begin
            c = b; c.aen = 1'b1; c.regnum = rx; exp_q.push_back(c);
            c = b; c.outen = 1'b1; c.done = 1'b1; exp_q.push_back(c);
        end else begin
            c = b; c.aen = 1'b1; c.regnum = (op == 3'b111) ? ry : rx;
            exp_q.push_back(c);
            c = b; c.ren = 1'b1; c.regnum = (op == 3'b111) ? '0 : ry;
            exp_q.push_back(c);
            c = b; c.rsel = 1'b1; c.regen = NREG'(1) << rx; c.done = 1'b1;
            exp_q.push_back(c);
        end
    endfunction

    // Called at a negedge with the FSM in IDLE; returns at the negedge of
    // the IDLE cycle following Done, after checking that cycle too.
    task automatic run_instr(input logic [INSTR_W-1:0] ins, input string tag,
                             input bit hold_run);
        build(ins);
        iin = ins;
        run = 1'b1;
        @(negedge clk);
        if (!hold_run) run = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_step%0d", tag, i), exp_q[i]);
            iin = INSTR_W'($urandom);   // must be ignored while busy
            @(negedge clk);
        end
        chk({tag, "_idle"}, '0);
    endtask

    initial begin
        logic [INSTR_W-1:0] r_ins;
        rst = 1'b1;
        run = 1'b0;
        iin = '0;
        repeat (2) @(negedge clk);
        chk("reset", '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", '0);

        run_instr(16'h0E80, "add_r3_r5", 1'b0);
        run_instr(16'hA955, "ldi_r2", 1'b0);
        run_instr(16'hFC80, "rep_r7_r1", 1'b0);
        run_instr(16'h6000, "illegal_011", 1'b0);
        run_instr(16'hC000, "illegal_110", 1'b0);
        run_instr(16'h4A40, "nand_r2_r4", 1'b0);
        run_instr(16'h3F80, "sub_rx_eq_ry", 1'b0);

        // Reset during T2 of sub, with Run also high: reset must win.
        build(16'h2E80);
        iin = 16'h2E80;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk("rst_mid_t1", exp_q[0]);
        @(negedge clk);
        chk("rst_mid_t2", exp_q[1]);
        rst = 1'b1;
        run = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        chk("rst_mid_after", '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_quiet%0d", i), '0);
        end

        // Run held high across out then add.
        run_instr(16'h9000, "held_out_r4", 1'b1);
        run_instr(16'h0E80, "held_add", 1'b0);

        // Randomised instructions with random idle gaps.
        for (int k = 0; k < 60; k++) begin
            r_ins = INSTR_W'($urandom);
            run_instr(r_ins, $sformatf("rnd%0d_%h", k, r_ins), 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(negedge clk);
                chk($sformatf("rnd%0d_gap%0d", k, g), '0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
